// File: rtl/fetch_queue.sv
// fetch_queue
// Instruction-fetch front end. Holds the PC, issues in-order requests to
// instruction memory, buffers returned instructions in a small FIFO and
// presents them to decode with a valid/stall handshake. A flush from the
// exception stage discards all in-flight and buffered work and restarts
// fetch at flush_addr. A misaligned flush target produces a single
// fetch-exception entry and blocks fetching until the next flush.
//
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   flush, flush_addr redirect request and target
//   imem_req_valid    fetch request valid       (out)
//   imem_req_ready    memory accepts request    (in)
//   imem_addr         fetch address = pc        (out)
//   imem_resp_valid   in-order response valid   (in)
//   imem_resp_data    fetched instruction       (in)
//   stall             decode cannot accept      (in)
//   instr_valid       FIFO head valid           (out)
//   PC, instr         head PC and instruction   (out)
//   fetch_exception   head is misaligned marker (out)

module fetch_queue #(
    parameter int                ADDR_W   = 32,
    parameter int                INSTR_W  = 32,
    parameter int                DEPTH    = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic [ADDR_W-1:0]  flush_addr,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_resp_valid,
    input  logic [INSTR_W-1:0] imem_resp_data,
    input  logic               stall,
    output logic               instr_valid,
    output logic [ADDR_W-1:0]  PC,
    output logic [INSTR_W-1:0] instr,
    output logic               fetch_exception
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [INSTR_W-1:0] NOP = INSTR_W'(32'h0000_0013);

    logic [ADDR_W-1:0]  fifo_pc    [DEPTH];
    logic [INSTR_W-1:0] fifo_instr [DEPTH];
    logic               fifo_exc   [DEPTH];
    logic [PW-1:0]      rd_ptr;
    logic [PW-1:0]      wr_ptr;
    logic [CW-1:0]      count;

    logic [ADDR_W-1:0]  pc;
    logic [ADDR_W-1:0]  resp_pc;
    logic [CW-1:0]      outstanding;
    logic [CW-1:0]      discard;
    logic               misaligned;

    logic [CW:0]        in_use;
    logic               handshake;
    logic               push;
    logic               pop;

    // Credit scheme: buffered plus outstanding never exceeds DEPTH, so a
    // response always finds a free FIFO slot and is never back-pressured.
    assign in_use         = {1'b0, count} + {1'b0, outstanding};
    assign imem_req_valid = !reset && !flush && !misaligned &&
                            (in_use < (CW+1)'(DEPTH));
    assign imem_addr      = pc;
    assign handshake      = imem_req_valid && imem_req_ready;
    assign push           = imem_resp_valid && (discard == '0);
    assign pop            = instr_valid && !stall;

    assign instr_valid     = (count != '0);
    assign PC              = instr_valid ? fifo_pc[rd_ptr]    : '0;
    assign instr           = instr_valid ? fifo_instr[rd_ptr] : '0;
    assign fetch_exception = instr_valid ? fifo_exc[rd_ptr]   : 1'b0;

    // A flush takes priority over everything else in its cycle. Responses
    // still owed by memory (including one arriving right now) are moved
    // into the discard count so that they are silently dropped later.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc          <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
            misaligned  <= 1'b0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_pc[i]    <= '0;
                fifo_instr[i] <= '0;
                fifo_exc[i]   <= 1'b0;
            end
        end else if (flush) begin
            discard     <= discard + outstanding - CW'(imem_resp_valid);
            outstanding <= '0;
            pc          <= flush_addr;
            resp_pc     <= flush_addr;
            rd_ptr      <= '0;
            if (flush_addr[1:0] != 2'b00) begin
                // The marker entry lives in slot 0 and blocks fetching.
                misaligned    <= 1'b1;
                fifo_pc[0]    <= flush_addr;
                fifo_instr[0] <= NOP;
                fifo_exc[0]   <= 1'b1;
                wr_ptr        <= PW'(1);
                count         <= CW'(1);
            end else begin
                misaligned <= 1'b0;
                wr_ptr     <= '0;
                count      <= '0;
            end
        end else begin
            if (handshake) begin
                pc <= pc + ADDR_W'(4);
            end
            if (imem_resp_valid && (discard != '0)) begin
                discard <= discard - CW'(1);
            end
            if (push) begin
                fifo_pc[wr_ptr]    <= resp_pc;
                fifo_instr[wr_ptr] <= imem_resp_data;
                fifo_exc[wr_ptr]   <= 1'b0;
                wr_ptr             <= wr_ptr + PW'(1);
                resp_pc            <= resp_pc + ADDR_W'(4);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            outstanding <= outstanding + CW'(handshake) - CW'(push);
            count       <= count + CW'(push) - CW'(pop);
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue
// Directed bench for fetch_queue. A memory model answers requests in order
// after a programmable latency with data = ~address. Each accepted request
// pushes its expected decode entry into a scoreboard; a separate monitor
// pops and compares whenever decode consumes an instruction.

`timescale 1ns/1ps

module tb_fetch_queue;

    logic        clk;
    logic        reset;
    logic        flush;
    logic [31:0] flush_addr;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        stall;
    logic        instr_valid;
    logic [31:0] head_pc;
    logic [31:0] instr;
    logic        fetch_exception;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        exc;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    exp_t        sb[$];
    pend_t       pend[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          hs_count = 0;
    int          pop_count = 0;
    int          latency;
    logic        req_allowed;
    logic [31:0] exp_req_addr;

    fetch_queue #(
        .ADDR_W   (32),
        .INSTR_W  (32),
        .DEPTH    (2),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .flush           (flush),
        .flush_addr      (flush_addr),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_addr       (imem_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .stall           (stall),
        .instr_valid     (instr_valid),
        .PC              (head_pc),
        .instr           (instr),
        .fetch_exception (fetch_exception)
    );

    // Free-running clock, posedge at 5 mod 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic f,
                                 input logic [31:0] fa, input logic rdy);
        stall          = s;
        flush          = f;
        flush_addr     = fa;
        imem_req_ready = rdy;
    endtask

    // Stop issuing and let every owed response and buffered entry drain.
    task automatic drainAll();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 40 && (pend.size() != 0 || instr_valid); i++) @(negedge clk);
        checkOutput("drain_done", 32'(pend.size() == 0 && !instr_valid), 32'd1);
    endtask

    // Memory model: drives responses at negedge+1, samples the request
    // handshake at negedge+3 and records the expected decode entry.
    initial begin
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        forever begin
            @(negedge clk);
            cyc++;
            #1;
            if (!reset && pend.size() > 0 && pend[0].due <= cyc) begin
                imem_resp_valid = 1'b1;
                imem_resp_data  = ~pend[0].addr;
                void'(pend.pop_front());
            end else begin
                imem_resp_valid = 1'b0;
                imem_resp_data  = '0;
            end
            #2;
            if (reset) begin
                pend.delete();
                imem_resp_valid = 1'b0;
            end else begin
                if (flush) checkOutput("flush_cycle_req_low", 32'(imem_req_valid), 32'd0);
                if (!req_allowed) checkOutput("req_blocked", 32'(imem_req_valid), 32'd0);
                if (imem_req_valid && imem_req_ready) begin
                    checkOutput("req_addr", imem_addr, exp_req_addr);
                    pend.push_back('{addr: imem_addr, due: cyc + latency});
                    sb.push_back('{exp_req_addr, ~exp_req_addr, 1'b0});
                    exp_req_addr = exp_req_addr + 32'd4;
                    hs_count++;
                end
            end
        end
    end

    // Monitor: compares every instruction decode consumes.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #4;
            if (!reset && !flush && instr_valid && !stall) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_instr", 32'(instr_valid), 32'd0);
                end else begin
                    e = sb.pop_front();
                    checkOutput("pop_pc", head_pc, e.pc);
                    checkOutput("pop_instr", instr, e.instr);
                    checkOutput("pop_exc", 32'(fetch_exception), 32'(e.exc));
                    pop_count++;
                end
            end
        end
    end

    initial begin
        logic [31:0] held;
        int          base;
        logic        found;

        reset        = 1'b1;
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        latency      = 1;
        req_allowed  = 1'b1;
        exp_req_addr = 32'h0;

        repeat (3) @(negedge clk);
        #1;
        checkOutput("reset_instr_valid", 32'(instr_valid), 32'd0);
        checkOutput("reset_req_valid", 32'(imem_req_valid), 32'd0);
        checkOutput("reset_pc", head_pc, 32'h0);
        checkOutput("reset_instr", instr, 32'h0);
        checkOutput("reset_exc", 32'(fetch_exception), 32'd0);

        // Streaming from RESET_PC with latency 1.
        @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("first_req_valid", 32'(imem_req_valid), 32'd1);
        checkOutput("first_req_addr", imem_addr, 32'h0);
        @(negedge clk);
        #1 checkOutput("no_bypass", 32'(instr_valid), 32'd0);
        @(negedge clk);
        #1;
        checkOutput("visible_after_resp", 32'(instr_valid), 32'd1);
        checkOutput("first_pc", head_pc, 32'h0);
        for (int i = 0; i < 40 && pop_count < 3; i++) @(negedge clk);
        checkOutput("stream_pops", 32'(pop_count >= 3), 32'd1);

        // Hold stall until the FIFO fills and requests stop.
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
        repeat (6) @(negedge clk);
        #1;
        held = (sb.size() > 0) ? sb[0].pc : 32'hDEAD_BEEF;
        checkOutput("stall_req_low", 32'(imem_req_valid), 32'd0);
        checkOutput("stall_valid", 32'(instr_valid), 32'd1);
        checkOutput("stall_head_pc", head_pc, held);
        repeat (3) @(negedge clk);
        #1 checkOutput("stall_pc_stable", head_pc, held);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        base = hs_count;
        for (int i = 0; i < 10 && hs_count == base; i++) @(negedge clk);
        checkOutput("requests_resume", 32'(hs_count != base), 32'd1);
        repeat (5) @(negedge clk);

        // Latency 3, two requests outstanding, flush to 0x100.
        drainAll();
        @(negedge clk);
        latency = 3;
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        base = hs_count;
        for (int i = 0; i < 10 && (hs_count - base) < 2; i++) @(negedge clk);
        checkOutput("two_outstanding", 32'(hs_count - base), 32'd2);
        applyStimulus(1'b0, 1'b1, 32'h100, 1'b1);
        sb.delete();
        exp_req_addr = 32'h100;
        #1 checkOutput("flush_req_low", 32'(imem_req_valid), 32'd0);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 32'h100, 1'b1);
        #1;
        checkOutput("post_flush_req", 32'(imem_req_valid), 32'd1);
        checkOutput("post_flush_addr", imem_addr, 32'h100);
        for (int i = 0; i < 20 && !instr_valid; i++) @(negedge clk);
        #1 checkOutput("first_pc_after_flush", head_pc, 32'h100);
        latency = 1;
        repeat (6) @(negedge clk);

        // Misaligned redirect with stall held in the flush cycle.
        applyStimulus(1'b1, 1'b1, 32'h102, 1'b1);
        sb.delete();
        sb.push_back('{32'h102, 32'h0000_0013, 1'b1});
        req_allowed = 1'b0;
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 32'h102, 1'b1);
        #1;
        checkOutput("mis_valid", 32'(instr_valid), 32'd1);
        checkOutput("mis_exc", 32'(fetch_exception), 32'd1);
        checkOutput("mis_pc", head_pc, 32'h102);
        checkOutput("mis_instr", instr, 32'h0000_0013);
        repeat (3) @(negedge clk);
        #1 checkOutput("mis_held_pc", head_pc, 32'h102);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 32'h102, 1'b1);
        @(negedge clk);
        #1 checkOutput("mis_popped", 32'(instr_valid), 32'd0);
        repeat (4) @(negedge clk);
        #1 checkOutput("mis_stays_empty", 32'(instr_valid), 32'd0);
        @(negedge clk);
        applyStimulus(1'b0, 1'b1, 32'h200, 1'b1);
        sb.delete();
        exp_req_addr = 32'h200;
        req_allowed  = 1'b1;
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 32'h200, 1'b1);
        #1;
        checkOutput("resume_req", 32'(imem_req_valid), 32'd1);
        checkOutput("resume_addr", imem_addr, 32'h200);
        for (int i = 0; i < 20 && !instr_valid; i++) @(negedge clk);
        #1 checkOutput("first_pc_0x200", head_pc, 32'h200);

        // Flush, response and pop all in one cycle.
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #2;
            if (imem_resp_valid && instr_valid) begin
                found = 1'b1;
                break;
            end
        end
        checkOutput("found_resp_pop_cycle", 32'(found), 32'd1);
        applyStimulus(1'b0, 1'b1, 32'h300, 1'b1);
        sb.delete();
        exp_req_addr = 32'h300;
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 32'h300, 1'b1);
        #1;
        checkOutput("same_cycle_fifo_empty", 32'(instr_valid), 32'd0);
        checkOutput("same_cycle_req", 32'(imem_req_valid), 32'd1);
        checkOutput("same_cycle_addr", imem_addr, 32'h300);
        repeat (6) @(negedge clk);

        // Asynchronous reset with two entries buffered.
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 20 && imem_req_valid; i++) @(negedge clk);
        repeat (4) @(negedge clk);
        #1 checkOutput("prereset_valid", 32'(instr_valid), 32'd1);
        #1 reset = 1'b1;
        #1;
        checkOutput("async_valid", 32'(instr_valid), 32'd0);
        checkOutput("async_pc", head_pc, 32'h0);
        checkOutput("async_instr", instr, 32'h0);
        checkOutput("async_exc", 32'(fetch_exception), 32'd0);
        checkOutput("async_req", 32'(imem_req_valid), 32'd0);
        sb.delete();
        exp_req_addr = 32'h0;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 20 && !instr_valid; i++) @(negedge clk);
        #1;
        checkOutput("restart_pc", head_pc, 32'h0);
        checkOutput("restart_instr", instr, 32'hFFFF_FFFF);
        repeat (4) @(negedge clk);
        #1;
        checkOutput("restart_pc_held", head_pc, 32'h0);
        checkOutput("restart_full_req_low", 32'(imem_req_valid), 32'd0);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        repeat (10) @(negedge clk);
        drainAll();
        checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Absolute time limit so the bench can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: got running expected finished");
        $fatal(1, "[TB] timeout");
    end

endmodule
